// File: rtl/chad_io_pkg.sv
// Shared constants for the chad I/O responder: register addresses and
// status/read-data bit positions.
package chad_io_pkg;

    typedef logic [2:0] io_addr_t;

    localparam io_addr_t IO_GPIO = 3'd0;
    localparam io_addr_t IO_GPIN = 3'd1;
    localparam io_addr_t IO_TXD  = 3'd2;
    localparam io_addr_t IO_RXD  = 3'd3;
    localparam io_addr_t IO_CYC  = 3'd4;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int RX_FULL_BIT = 8;

endpackage

// File: rtl/chad_fifo.sv
// Small synchronous FIFO with registered storage; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module chad_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r ^ rd_ptr_r) == {1'b1, {AW{1'b0}}};
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update; push and pop may both happen in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chad_io.sv
// I/O responder for the chad core: GPIO, TX FIFO, RX holding register and a
// cycle counter behind the io_rd/io_wr strobe interface with one read wait state.
module chad_io
    import chad_io_pkg::*;
#(
    parameter int WIDTH   = 18,
    parameter int GPIO_W  = 8,
    parameter int TXDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [14:0]       mem_addr,
    input  logic [WIDTH-1:0]  dout,
    output logic [WIDTH-1:0]  io_din,
    output logic              hold,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    io_addr_t          addr_s;
    logic              wr_s;
    logic              tx_full_s;
    logic              tx_empty_s;
    logic              tx_push_s;
    logic              tx_pop_s;
    logic [WIDTH-1:0]  rmux_s;
    logic              rd_done_r;
    logic              rd_pop_r;
    logic [WIDTH-1:0]  rdata_r;
    logic              rx_full_r;
    logic [7:0]        rx_byte_r;
    logic [GPIO_W-1:0] gpio_out_r;
    logic [WIDTH-1:0]  cyc_r;
    logic              unused_s;

    assign addr_s    = mem_addr[2:0];
    // A read strobe wins over a simultaneous write strobe.
    assign wr_s      = io_wr & ~io_rd;
    assign tx_push_s = wr_s & (addr_s == IO_TXD) & ~tx_full_s;
    assign tx_pop_s  = tx_ready & ~tx_empty_s;
    assign hold      = (io_rd & ~rd_done_r) | (io_wr & (addr_s == IO_TXD) & tx_full_s);
    assign io_din    = rdata_r;
    assign gpio_out  = gpio_out_r;
    assign tx_valid  = ~tx_empty_s;
    assign rx_ready  = ~rx_full_r;
    assign unused_s  = ^{mem_addr[14:3], dout};

    chad_fifo #(.WIDTH(8), .DEPTH(TXDEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (dout[7:0]),
        .head  (tx_data),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    // Read data mux, sampled into rdata_r on the capture cycle.
    always_comb begin
        rmux_s = '0;
        case (addr_s)
            IO_GPIO: rmux_s[GPIO_W-1:0] = gpio_out_r;
            IO_GPIN: rmux_s[GPIO_W-1:0] = gpio_in;
            IO_TXD: begin
                rmux_s[ST_RX_FULL]  = rx_full_r;
                rmux_s[ST_TX_FULL]  = tx_full_s;
                rmux_s[ST_TX_EMPTY] = tx_empty_s;
            end
            IO_RXD: begin
                rmux_s[RX_FULL_BIT] = rx_full_r;
                rmux_s[7:0]         = rx_full_r ? rx_byte_r : 8'h00;
            end
            IO_CYC:  rmux_s = cyc_r;
            default: rmux_s = '0;
        endcase
    end

    // Two-cycle read: capture into rdata_r, then complete and release hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_done_r <= 1'b0;
            rd_pop_r  <= 1'b0;
            rdata_r   <= '0;
        end else if (rd_done_r) begin
            rd_done_r <= 1'b0;
            rd_pop_r  <= 1'b0;
        end else if (io_rd) begin
            rd_done_r <= 1'b1;
            rd_pop_r  <= (addr_s == IO_RXD) & rx_full_r;
            rdata_r   <= rmux_s;
        end
    end

    // RX holding register; the pop flag is latched at capture so a byte
    // arriving between capture and complete is never dropped unread.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_full_r <= 1'b0;
            rx_byte_r <= 8'h00;
        end else if (rd_done_r & rd_pop_r) begin
            rx_full_r <= 1'b0;
        end else if (rx_valid & ~rx_full_r) begin
            rx_full_r <= 1'b1;
            rx_byte_r <= rx_data;
        end
    end

    // GPIO output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out_r <= '0;
        end else if (wr_s & (addr_s == IO_GPIO)) begin
            gpio_out_r <= dout[GPIO_W-1:0];
        end
    end

    // Free-running cycle counter; a write clears it ahead of the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_r <= '0;
        end else if (wr_s & (addr_s == IO_CYC)) begin
            cyc_r <= '0;
        end else begin
            cyc_r <= cyc_r + 1'b1;
        end
    end

endmodule

// File: tb/tb_chad_io.sv
// Directed self-checking bench for chad_io with the default parameters
// (WIDTH=18, GPIO_W=8, TXDEPTH=4).
module tb_chad_io;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_rd;
    logic        io_wr;
    logic [14:0] mem_addr;
    logic [17:0] dout;
    logic [17:0] io_din;
    logic        hold;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int tests = 0;
    int fails = 0;

    chad_io dut (
        .clk      (clk),
        .reset    (reset),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .mem_addr (mem_addr),
        .dout     (dout),
        .io_din   (io_din),
        .hold     (hold),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_read(input logic [2:0] a, output logic [17:0] d, output int hc);
        io_rd = 1'b1;
        mem_addr = {12'd0, a};
        hc = 0;
        #1;
        while (hold && hc < 8) begin
            hc++;
            tick;
        end
        d = io_din;
        tick;
        io_rd = 1'b0;
    endtask

    task do_write(input logic [2:0] a, input logic [17:0] v, output int hc);
        io_wr = 1'b1;
        mem_addr = {12'd0, a};
        dout = v;
        hc = 0;
        #1;
        while (hold && hc < 8) begin
            hc++;
            tick;
        end
        tick;
        io_wr = 1'b0;
    endtask

    task test_reset;
        reset = 1'b1;
        repeat (3) tick;
        tests++; if (hold !== 1'b0) begin fails++; $display("FAIL reset_hold got %b exp 0", hold); end
        tests++; if (io_din !== 18'h0) begin fails++; $display("FAIL reset_io_din got %h exp 0", io_din); end
        tests++; if (gpio_out !== 8'h00) begin fails++; $display("FAIL reset_gpio got %h exp 0", gpio_out); end
        tests++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx got v=%b d=%h exp v=0 d=00", tx_valid, tx_data); end
        tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready); end
        tests++; if (dut.cyc_r !== 18'h0) begin fails++; $display("FAIL reset_cyc got %h exp 0", dut.cyc_r); end
        reset = 1'b0;
    endtask

    task test_cycle_counter;
        logic [17:0] c1, c2, diff, d;
        int h1, h2, hw;
        do_read(3'd4, c1, h1);
        repeat (8) tick;
        do_read(3'd4, c2, h2);
        diff = c2 - c1;
        tests++; if (h1 !== 1 || h2 !== 1) begin fails++; $display("FAIL cyc_hold got %0d,%0d exp 1,1", h1, h2); end
        tests++; if (diff !== 18'd10) begin fails++; $display("FAIL cyc_diff got %0d exp 10", diff); end
        do_write(3'd4, 18'h3FFFF, hw);
        do_read(3'd4, d, h1);
        tests++; if (d !== 18'h0) begin fails++; $display("FAIL cyc_clear got %h exp 0", d); end
    endtask

    task test_gpio;
        logic [17:0] d;
        int hc;
        do_write(3'd0, 18'h2C0A5, hc);
        tests++; if (hc !== 0) begin fails++; $display("FAIL gpio_wr_hold got %0d exp 0", hc); end
        tests++; if (gpio_out !== 8'hA5) begin fails++; $display("FAIL gpio_out got %h exp a5", gpio_out); end
        do_read(3'd0, d, hc);
        tests++; if (d !== 18'h000A5) begin fails++; $display("FAIL gpio_rd got %h exp 000a5", d); end
        gpio_in = 8'h5A;
        do_read(3'd1, d, hc);
        tests++; if (d !== 18'h0005A) begin fails++; $display("FAIL gpin_rd got %h exp 0005a", d); end
        do_write(3'd5, 18'h12345, hc);
        do_read(3'd5, d, hc);
        tests++; if (d !== 18'h0 || gpio_out !== 8'hA5) begin fails++; $display("FAIL unused_addr got %h gpio %h exp 0 a5", d, gpio_out); end
        // Simultaneous strobes: the read completes, the GPIO write is dropped.
        io_rd = 1'b1; io_wr = 1'b1; mem_addr = 15'd0; dout = 18'h000FF;
        tick; tick;
        io_rd = 1'b0; io_wr = 1'b0;
        tests++; if (gpio_out !== 8'hA5 || io_din !== 18'h000A5) begin fails++; $display("FAIL rd_wr_both got gpio %h din %h exp a5 000a5", gpio_out, io_din); end
    endtask

    task test_status_empty;
        logic [17:0] d;
        int hc;
        do_read(3'd2, d, hc);
        tests++; if (d !== 18'h001) begin fails++; $display("FAIL status_empty got %h exp 001", d); end
    endtask

    task test_tx_fifo;
        logic [17:0] d;
        int hc;
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            do_write(3'd2, 18'(i), hc);
            tests++; if (hc !== 0) begin fails++; $display("FAIL tx_push%0d_hold got %0d exp 0", i, hc); end
        end
        tests++; if (tx_valid !== 1'b1 || tx_data !== 8'd1) begin fails++; $display("FAIL tx_head got v=%b d=%h exp v=1 d=01", tx_valid, tx_data); end
        do_read(3'd2, d, hc);
        tests++; if (d !== 18'h002) begin fails++; $display("FAIL status_full got %h exp 002", d); end
        io_wr = 1'b1; mem_addr = 15'd2; dout = 18'd5;
        #1;
        tests++; if (hold !== 1'b1) begin fails++; $display("FAIL tx_full_hold0 got %b exp 1", hold); end
        tick;
        tests++; if (hold !== 1'b1) begin fails++; $display("FAIL tx_full_hold1 got %b exp 1", hold); end
        tx_ready = 1'b1;
        #1;
        tests++; if (hold !== 1'b1) begin fails++; $display("FAIL tx_drain_cycle_hold got %b exp 1", hold); end
        tick;
        tx_ready = 1'b0;
        #1;
        tests++; if (hold !== 1'b0 || tx_data !== 8'd2) begin fails++; $display("FAIL tx_release got hold=%b d=%h exp 0 02", hold, tx_data); end
        tick;
        io_wr = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            tests++; if (tx_valid !== 1'b1 || tx_data !== 8'(k)) begin fails++; $display("FAIL tx_drain got v=%b d=%h exp v=1 d=%h", tx_valid, tx_data, 8'(k)); end
            tx_ready = 1'b1;
            tick;
            tx_ready = 1'b0;
        end
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL tx_empty_after got %b exp 0", tx_valid); end
    endtask

    task test_rx;
        logic [17:0] d;
        int hc;
        rx_data = 8'h3C;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL rx_ready_full got %b exp 0", rx_ready); end
        do_read(3'd2, d, hc);
        tests++; if (d !== 18'h005) begin fails++; $display("FAIL status_rx got %h exp 005", d); end
        do_read(3'd3, d, hc);
        tests++; if (d !== 18'h13C) begin fails++; $display("FAIL rx_rd1 got %h exp 13c", d); end
        tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL rx_ready_pop got %b exp 1", rx_ready); end
        do_read(3'd3, d, hc);
        tests++; if (d !== 18'h000) begin fails++; $display("FAIL rx_rd2 got %h exp 000", d); end
    endtask

    task test_reset_mid_read;
        logic [17:0] d;
        int hc;
        do_write(3'd2, 18'h77, hc);
        do_read(3'd4, d, hc);
        io_rd = 1'b1; mem_addr = 15'd4;
        #1;
        tests++; if (hold !== 1'b1) begin fails++; $display("FAIL midrd_capture_hold got %b exp 1", hold); end
        reset = 1'b1;
        tick;
        io_rd = 1'b0;
        #1;
        tests++; if (hold !== 1'b0 || io_din !== 18'h0) begin fails++; $display("FAIL midrd_reset got hold=%b din=%h exp 0 0", hold, io_din); end
        tests++; if (dut.cyc_r !== 18'h0 || tx_valid !== 1'b0) begin fails++; $display("FAIL midrd_state got cyc=%h txv=%b exp 0 0", dut.cyc_r, tx_valid); end
        reset = 1'b0;
        tick;
    endtask

    initial begin
        reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; mem_addr = 15'd0; dout = 18'd0;
        gpio_in = 8'h00; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        test_reset;
        test_cycle_counter;
        test_gpio;
        test_status_empty;
        test_tx_fifo;
        test_rx;
        test_reset_mid_read;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
